// File: rtl/flash_model_responder.sv
// rtl/flash_model_responder.sv - BRAM-backed responder model of the flash manager client protocol
//
// Purpose: stands in for the flash manager. Accepts sequential 16-bit sample
// writes and random-address reads, reproduces the busy handshake, the
// post-reset erase to 16'hFFFF and configurable per-operation latencies.
//
// Ports:
//   clock      system clock, rising edge
//   reset_b    synchronous active-low reset
//   writemode  1 = write/erase mode, 0 = read mode
//   wdata      write data, taken on an accepted dowrite
//   dowrite    write request (IDLE, writemode=1)
//   raddr      read word address, low ADDR_W bits used
//   doread     read request (IDLE, writemode=0)
//   frdata     data of the last completed read, held between reads
//   busy       responder occupied; requests are dropped while high
//   wcount     words written since the last erase
//   overflow   sticky, write attempted with the memory full
//   fsmstate   {8'b0, READ, WRITE, ERASE, INIT} one-hot, IDLE = 0

module flash_model_responder #(
    parameter int ADDR_W    = 10,
    parameter int WRITE_LAT = 4,
    parameter int READ_LAT  = 2
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              writemode,
    input  logic [15:0]       wdata,
    input  logic              dowrite,
    input  logic [22:0]       raddr,
    input  logic              doread,
    output logic [15:0]       frdata,
    output logic              busy,
    output logic [ADDR_W:0]   wcount,
    output logic              overflow,
    output logic [11:0]       fsmstate
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_LAT = (WRITE_LAT > READ_LAT) ? WRITE_LAT : READ_LAT;
    // The counter holds LAT-1 down to 0.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_ERASE,
        S_IDLE,
        S_WRITE,
        S_READ
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                init_hold_q;
    logic [ADDR_W-1:0]   erase_ptr_q;
    logic [CNT_W-1:0]    lat_cnt_q;
    logic [15:0]         rd_data_q;
    logic [15:0]         mem [DEPTH];

    logic                full;
    logic                wr_req;
    logic                wr_go;
    logic                rd_go;
    logic                lat_done;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [15:0]         mem_wdata;
    logic                unused_raddr_hi;

    // wcount never exceeds DEPTH, so its MSB alone flags a full memory.
    assign full     = wcount[ADDR_W];
    assign wr_req   = (state_q == S_IDLE) && writemode && dowrite;
    assign wr_go    = wr_req && !full;
    assign rd_go    = (state_q == S_IDLE) && !writemode && doread;
    assign lat_done = (lat_cnt_q == '0);

    assign unused_raddr_hi = ^raddr[22:ADDR_W];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        fsmstate = 12'h000;
        case (state_q)
            S_INIT: begin
                fsmstate[0] = 1'b1;
                // INIT occupies the whole cycle after the release edge; the
                // mode decision is taken on the edge that follows it.
                if (!init_hold_q) begin
                    state_d = writemode ? S_ERASE : S_IDLE;
                end
            end
            S_ERASE: begin
                fsmstate[1] = 1'b1;
                if (&erase_ptr_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                busy = 1'b0;
                // A write at full stays in IDLE: only overflow reacts.
                if (wr_go) begin
                    state_d = S_WRITE;
                end else if (rd_go) begin
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                fsmstate[2] = 1'b1;
                if (lat_done) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                fsmstate[3] = 1'b1;
                if (lat_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control datapath: erase pointer, latency counter, counters, read data
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            init_hold_q <= 1'b1;
            erase_ptr_q <= '0;
            lat_cnt_q   <= '0;
            wcount      <= '0;
            overflow    <= 1'b0;
            frdata      <= 16'h0000;
        end else begin
            init_hold_q <= 1'b0;

            if (state_q == S_ERASE) begin
                erase_ptr_q <= erase_ptr_q + ADDR_W'(1);
            end

            if (wr_go) begin
                wcount    <= wcount + (ADDR_W+1)'(1);
                lat_cnt_q <= CNT_W'(WRITE_LAT - 1);
            end else if (wr_req) begin
                overflow  <= 1'b1;
            end

            if (rd_go) begin
                lat_cnt_q <= CNT_W'(READ_LAT - 1);
            end

            if ((state_q == S_WRITE || state_q == S_READ) && !lat_done) begin
                lat_cnt_q <= lat_cnt_q - CNT_W'(1);
            end

            if (state_q == S_READ && lat_done) begin
                frdata <= rd_data_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory: one write port shared by erase and client writes, one
    // synchronous read port. The word is fetched on the acceptance edge;
    // nothing can write the array while a read is in flight, so holding
    // the data instead of the address gives the same result.
    // ------------------------------------------------------------------
    assign mem_we    = reset_b && ((state_q == S_ERASE) || wr_go);
    assign mem_waddr = (state_q == S_ERASE) ? erase_ptr_q : wcount[ADDR_W-1:0];
    assign mem_wdata = (state_q == S_ERASE) ? 16'hFFFF : wdata;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_go) begin
            rd_data_q <= mem[raddr[ADDR_W-1:0]];
        end
    end

endmodule
